ascon_ctrl: RTL and testbench

Sequencing controller between the APB register file and the Ascon permutation core. It turns a start request plus AD/PT block counts into a series of core operations: INIT, AD blocks, PT blocks, FINAL. It pops the AD and PT FIFOs, pushes ciphertext into the CT FIFO, and inserts a programmable idle delay after every core operation. On completion it latches the 128-bit tag and reports status back to the register file.

---
 rtl/ascon_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ascon_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : ascon_ctrl                                                      |
// | Brief   : Sequences INIT/AD/PT/FINAL Ascon core ops with FIFO handshakes. |
// |           Optional macro ASCON_CTRL_TRIGGER_EN adds trigger_o.            |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ascon_ctrl #(
  parameter int DataAddrWidth = 7,
  parameter int DelayWidth    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef ASCON_CTRL_TRIGGER_EN
  output logic                     trigger_o,
`endif
  input  logic                     start_i,
  input  logic [DataAddrWidth-1:0] ad_size_i,
  input  logic [DataAddrWidth-1:0] pt_size_i,
  input  logic [DelayWidth-1:0]    delay_i,
  output logic                     ready_o,
  output logic                     tag_valid_o,
  output logic [127:0]             tag_o,
  output logic                     ad_pop_o,
  input  logic [63:0]              ad_i,
  input  logic                     ad_empty_i,
  output logic                     pt_pop_o,
  input  logic [63:0]              pt_i,
  input  logic                     pt_empty_i,
  output logic                     ct_push_o,
  output logic [63:0]              ct_o,
  input  logic                     ct_full_i,
  output logic                     core_valid_o,
  output logic [1:0]               core_op_o,
  output logic [63:0]              core_data_o,
  output logic                     core_last_o,
  input  logic                     core_ready_i,
  input  logic                     core_done_i,
  input  logic [63:0]              core_data_i,
  input  logic [127:0]             core_tag_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_BUSY  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] c_op_init  = 2'd0;
  localparam logic [1:0] c_op_ad    = 2'd1;
  localparam logic [1:0] c_op_pt    = 2'd2;
  localparam logic [1:0] c_op_final = 2'd3;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [1:0]               r_phase;
  logic [1:0]               w_next_phase;
  logic                     r_start_q;
  logic [DataAddrWidth-1:0] r_ad_cnt;
  logic [DataAddrWidth-1:0] r_pt_cnt;
  logic [DelayWidth-1:0]    r_delay;
  logic [DelayWidth-1:0]    r_wait_cnt;
  logic                     r_tag_valid;
  logic [127:0]             r_tag;

  logic       w_start_edge;
  logic [1:0] w_after;
  logic       w_op_ok;
  logic       w_handshake;
  logic       w_done;
  logic       w_step;
  logic       w_finish;
  logic       w_issue;

  assign w_start_edge = start_i & ~r_start_q;

  // Counts are already decremented at handshake, so this picks the op after the current one.
  assign w_after = (r_ad_cnt != '0) ? c_op_ad :
                   (r_pt_cnt != '0) ? c_op_pt : c_op_final;

  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_op_ok      = 1'b0;
    w_handshake  = 1'b0;
    w_done       = 1'b0;
    w_step       = 1'b0;
    w_finish     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_next_state = S_ISSUE;
          w_next_phase = c_op_init;
        end
      end
      S_ISSUE: begin
        unique case (r_phase)
          c_op_ad: w_op_ok = ~ad_empty_i;
          // The CT slot is reserved here; nothing else pushes CT before the done.
          c_op_pt: w_op_ok = ~pt_empty_i & ~ct_full_i;
          default: w_op_ok = 1'b1;
        endcase
        if (w_op_ok && core_ready_i) begin
          w_handshake  = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (core_done_i) begin
          w_done = 1'b1;
          if (r_delay != '0) w_next_state = S_WAIT;
          else               w_step       = 1'b1;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt <= DelayWidth'(1)) w_step = 1'b1;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_step) begin
      if (r_phase == c_op_final) begin
        w_next_state = S_IDLE;
        w_finish     = 1'b1;
      end else begin
        w_next_state = S_ISSUE;
        w_next_phase = w_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_phase <= c_op_init;
    end else begin
      r_state <= w_next_state;
      r_phase <= w_next_phase;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_start_q   <= 1'b0;
      r_ad_cnt    <= '0;
      r_pt_cnt    <= '0;
      r_delay     <= '0;
      r_wait_cnt  <= '0;
      r_tag_valid <= 1'b0;
      r_tag       <= '0;
    end else begin
      r_start_q <= start_i;
      if (r_state == S_IDLE && w_start_edge) begin
        r_ad_cnt    <= ad_size_i;
        r_pt_cnt    <= pt_size_i;
        r_delay     <= delay_i;
        r_tag_valid <= 1'b0;
      end
      if (w_handshake && r_phase == c_op_ad) r_ad_cnt <= r_ad_cnt - DataAddrWidth'(1);
      if (w_handshake && r_phase == c_op_pt) r_pt_cnt <= r_pt_cnt - DataAddrWidth'(1);
      if (w_done) begin
        r_wait_cnt <= r_delay;
        if (r_phase == c_op_final) r_tag <= core_tag_i;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt - DelayWidth'(1);
      end
      if (w_finish) r_tag_valid <= 1'b1;
    end
  end

  // Strobes are masked by rst_n so a reset cycle never pops or pushes.
  assign w_issue      = rst_n & (r_state == S_ISSUE);
  assign ready_o      = (r_state == S_IDLE);
  assign tag_valid_o  = r_tag_valid;
  assign tag_o        = r_tag;
  assign core_valid_o = w_issue & w_op_ok;
  assign core_op_o    = w_issue ? r_phase : c_op_init;
  assign core_data_o  = !w_issue              ? 64'd0 :
                        (r_phase == c_op_ad)  ? ad_i  :
                        (r_phase == c_op_pt)  ? pt_i  : 64'd0;
  assign core_last_o  = w_issue &
                        (((r_phase == c_op_ad) && (r_ad_cnt == DataAddrWidth'(1))) ||
                         ((r_phase == c_op_pt) && (r_pt_cnt == DataAddrWidth'(1))));
  assign ad_pop_o     = rst_n & w_handshake & (r_phase == c_op_ad);
  assign pt_pop_o     = rst_n & w_handshake & (r_phase == c_op_pt);
  assign ct_push_o    = rst_n & w_done & (r_phase == c_op_pt);
  assign ct_o         = ct_push_o ? core_data_i : 64'd0;

`ifdef ASCON_CTRL_TRIGGER_EN
  logic r_trigger;

  always_ff @(posedge clk) begin
    if (!rst_n) r_trigger <= 1'b0;
    else        r_trigger <= (w_next_state == S_BUSY) && (w_next_phase != c_op_init);
  end

  assign trigger_o = r_trigger;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ascon_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for ascon_ctrl: FIFO and core models plus an op/CT scoreboard.
module tb_ascon_ctrl;
  localparam int AW  = 7;
  localparam int DW  = 16;
  localparam int LAT = 4;
  localparam logic [1:0]  OP_INIT = 2'd0, OP_AD = 2'd1, OP_PT = 2'd2, OP_FINAL = 2'd3;
  localparam logic [63:0] CT_KEY  = 64'h5a5a_0f0f_c3c3_9696;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start_i, ready_o, tag_valid_o;
  logic [AW-1:0] ad_size_i, pt_size_i;
  logic [DW-1:0] delay_i;
  logic [127:0]  tag_o, core_tag_i;
  logic          ad_pop_o, ad_empty_i, pt_pop_o, pt_empty_i, ct_push_o, ct_full_i;
  logic [63:0]   ad_i, pt_i, ct_o, core_data_o, core_data_i;
  logic          core_valid_o, core_last_o, core_ready_i, core_done_i;
  logic [1:0]    core_op_o;

  ascon_ctrl #(.DataAddrWidth(AW), .DelayWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .ad_size_i(ad_size_i),
    .pt_size_i(pt_size_i), .delay_i(delay_i), .ready_o(ready_o),
    .tag_valid_o(tag_valid_o), .tag_o(tag_o), .ad_pop_o(ad_pop_o), .ad_i(ad_i),
    .ad_empty_i(ad_empty_i), .pt_pop_o(pt_pop_o), .pt_i(pt_i), .pt_empty_i(pt_empty_i),
    .ct_push_o(ct_push_o), .ct_o(ct_o), .ct_full_i(ct_full_i),
    .core_valid_o(core_valid_o), .core_op_o(core_op_o), .core_data_o(core_data_o),
    .core_last_o(core_last_o), .core_ready_i(core_ready_i), .core_done_i(core_done_i),
    .core_data_i(core_data_i), .core_tag_i(core_tag_i)
  );

  int n_checks = 0, n_fail = 0;
  int cyc = 0, done_cyc = 0, exp_gap = 1, n_pt_hs = 0;
  bit gap_arm = 1'b0, gap_en = 1'b0;

  logic [63:0] ad_mem [0:127];
  logic [63:0] pt_mem [0:127];
  int ad_wr = 0, ad_rd = 0, pt_wr = 0, pt_rd = 0, pt_hold = 0;

  logic [1:0]  exp_op   [0:127];
  logic [63:0] exp_data [0:127];
  logic        exp_last [0:127];
  int exp_wr = 0, exp_rd = 0;
  logic [63:0] ct_exp [0:127];
  int ct_wr = 0, ct_rd = 0;

  bit          pend_hs = 1'b0, pend_ad_pop = 1'b0, pend_pt_pop = 1'b0;
  logic [1:0]  pend_op = 2'd0, tmr_op = 2'd0, done_op = 2'd0;
  logic [63:0] pend_data = 64'd0, tmr_data = 64'd0;
  logic [127:0] run_tag = 128'd0;
  int tmr = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [63:0] d, input logic last);
    exp_op[exp_wr] = op; exp_data[exp_wr] = d; exp_last[exp_wr] = last;
    exp_wr++;
  endtask

  // Samples DUT outputs mid-cycle and consumes scoreboard entries.
  task automatic monitor();
    bit hs;
    cyc++;
    hs = core_valid_o && core_ready_i;
    if (!rst_n) chk("rst_quiet", 128'({ad_pop_o, pt_pop_o, ct_push_o, core_valid_o}), 128'd0);
    if (gap_arm && core_valid_o) begin
      if (gap_en) chk("gap", 128'(cyc - done_cyc), 128'(exp_gap));
      gap_arm = 1'b0;
    end
    if (hs) begin
      chk("op_expected", 128'(exp_rd < exp_wr), 128'd1);
      if (exp_rd < exp_wr) begin
        chk("op", 128'(core_op_o), 128'(exp_op[exp_rd]));
        chk("data", 128'(core_data_o), 128'(exp_data[exp_rd]));
        chk("last", 128'(core_last_o), 128'(exp_last[exp_rd]));
        exp_rd++;
      end
      if (core_op_o == OP_PT) n_pt_hs++;
    end
    if (hs || ad_pop_o || pt_pop_o) begin
      chk("ad_pop", 128'(ad_pop_o), 128'(hs && core_op_o == OP_AD));
      chk("pt_pop", 128'(pt_pop_o), 128'(hs && core_op_o == OP_PT));
    end
    if (ct_push_o) begin
      chk("ct_expected", 128'(ct_rd < ct_wr), 128'd1);
      if (ct_rd < ct_wr) chk("ct", 128'(ct_o), 128'(ct_exp[ct_rd]));
      ct_rd++;
    end
    if (core_done_i) begin
      done_cyc = cyc;
      gap_arm  = (done_op != OP_FINAL);
    end
    pend_hs = hs; pend_op = core_op_o; pend_data = core_data_o;
    pend_ad_pop = ad_pop_o; pend_pt_pop = pt_pop_o;
  endtask

  // FIFO and core behaviour applied just after the active edge.
  task automatic model();
    if (pend_ad_pop) ad_rd++;
    if (pend_pt_pop) pt_rd++;
    ad_empty_i = (ad_rd >= ad_wr);
    ad_i = ad_empty_i ? 64'd0 : ad_mem[ad_rd];
    pt_empty_i = (pt_rd >= pt_wr);
    pt_i = pt_empty_i ? 64'd0 : pt_mem[pt_rd];
    core_done_i = 1'b0;
    if (pend_hs) begin
      tmr = LAT; tmr_op = pend_op; tmr_data = pend_data;
    end else if (tmr != 0) begin
      if (tmr == 1) begin
        core_done_i = 1'b1;
        done_op     = tmr_op;
        core_data_i = tmr_data ^ CT_KEY;
        core_tag_i  = (tmr_op == OP_FINAL) ? run_tag : ~run_tag;
      end
      tmr--;
    end
  endtask

  task automatic step();
    @(negedge clk); monitor();
    @(posedge clk); #1; model();
  endtask

  task automatic prep(input int nad, input int npt, input int dly,
                      input logic [127:0] tag, input bit load_pt);
    logic [63:0] d;
    push_exp(OP_INIT, 64'd0, 1'b0);
    for (int i = 0; i < nad; i++) begin
      d = {$urandom(), $urandom()};
      ad_mem[ad_wr] = d; ad_wr++;
      push_exp(OP_AD, d, i == nad - 1);
    end
    for (int i = 0; i < npt; i++) begin
      d = {$urandom(), $urandom()};
      pt_mem[pt_wr + i] = d;
      ct_exp[ct_wr] = d ^ CT_KEY; ct_wr++;
      push_exp(OP_PT, d, i == npt - 1);
    end
    if (load_pt) pt_wr += npt;
    else         pt_hold = npt;
    push_exp(OP_FINAL, 64'd0, 1'b0);
    ad_size_i = AW'(nad); pt_size_i = AW'(npt); delay_i = DW'(dly);
    run_tag = tag; exp_gap = dly + 1; gap_en = 1'b1;
  endtask

  task automatic fire();
    start_i = 1'b1;
    step();
    chk("issue_after_start", 128'({ready_o, core_valid_o, core_op_o}), 128'({1'b0, 1'b1, OP_INIT}));
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && !ready_o; i++) step();
    chk("done_in_time", 128'(ready_o), 128'd1);
    chk("tag_valid", 128'(tag_valid_o), 128'd1);
    chk("tag", tag_o, run_tag);
    chk("ops_all", 128'(exp_rd), 128'(exp_wr));
    chk("ct_all", 128'(ct_rd), 128'(ct_wr));
  endtask

  task automatic stall_check(input string tag);
    for (int i = 0; i < 200 && core_op_o != OP_PT; i++) step();
    chk("reach_pt", 128'(core_op_o), 128'(OP_PT));
    for (int i = 0; i < 10; i++) begin
      chk(tag, 128'(core_valid_o), 128'd0);
      step();
    end
  endtask

  initial begin
    int base, ct_base;
    rst_n = 1'b0; start_i = 1'b0; ad_size_i = '0; pt_size_i = '0; delay_i = '0;
    ct_full_i = 1'b0; core_ready_i = 1'b1; core_data_i = '0; core_tag_i = '0;
    model();
    step(); step();
    chk("rst_ready", 128'(ready_o), 128'd1);
    chk("rst_strobes", 128'({tag_valid_o, core_valid_o, core_last_o, ad_pop_o, pt_pop_o, ct_push_o}), 128'd0);
    chk("rst_tag", tag_o, 128'd0);
    chk("rst_op_data", 128'({core_op_o, core_data_o}), 128'd0);
    rst_n = 1'b1;
    step();

    // Full run: 2 AD, 3 PT, no delay.
    prep(2, 3, 0, 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210, 1'b1);
    fire(); start_i = 1'b0;
    wait_done();

    // Empty AD and PT: INIT then FINAL only.
    base = ad_rd + pt_rd;
    prep(0, 0, 0, 128'hdead_beef_0000_1111_2222_3333_4444_5555, 1'b1);
    fire(); start_i = 1'b0;
    wait_done();
    chk("no_pops", 128'(ad_rd + pt_rd), 128'(base));

    // Five idle cycles after each op.
    prep(1, 1, 5, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1);
    fire(); start_i = 1'b0;
    wait_done();

    // PT FIFO empty at PT phase.
    prep(1, 1, 0, 128'haaaa_bbbb_cccc_dddd_eeee_ffff_0000_1234, 1'b0);
    gap_en = 1'b0;
    fire(); start_i = 1'b0;
    stall_check("pt_empty_stall");
    pt_wr += pt_hold;
    wait_done();

    // CT FIFO full at PT phase.
    prep(0, 1, 0, 128'h5555_aaaa_5555_aaaa_0f0f_f0f0_1357_9bdf, 1'b1);
    gap_en = 1'b0;
    ct_full_i = 1'b1;
    fire(); start_i = 1'b0;
    stall_check("ct_full_stall");
    ct_full_i = 1'b0;
    wait_done();

    // Start held high through completion: one run only.
    prep(0, 1, 0, 128'h0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0, 1'b1);
    fire();
    wait_done();
    for (int i = 0; i < 10; i++) step();
    chk("hold_no_retrigger", 128'({ready_o, 32'(exp_rd)}), 128'({1'b1, 32'(exp_wr)}));
    start_i = 1'b0;
    step();

    // Fresh start edge while BUSY is ignored.
    prep(0, 0, 0, 128'hcafe_f00d_0000_0000_1234_5678_9abc_def0, 1'b1);
    fire();
    step();
    start_i = 1'b0; step();
    start_i = 1'b1; step();
    wait_done();
    for (int i = 0; i < 10; i++) step();
    chk("busy_edge_ignored", 128'({ready_o, 32'(exp_rd)}), 128'({1'b1, 32'(exp_wr)}));
    start_i = 1'b0;
    step();

    // Reset while BUSY on the second PT block.
    ct_base = ct_wr;
    prep(0, 3, 0, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 1'b1);
    fire(); start_i = 1'b0;
    base = n_pt_hs;
    for (int i = 0; i < 500 && n_pt_hs < base + 2; i++) step();
    chk("reach_pt2", 128'(n_pt_hs), 128'(base + 2));
    rst_n = 1'b0; gap_en = 1'b0;
    step();
    chk("rst_mid_ready", 128'(ready_o), 128'd1);
    chk("rst_mid_tag_valid", 128'(tag_valid_o), 128'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("no_pending_ct", 128'(ct_rd), 128'(ct_base + 1));
    chk("idle_after_rst", 128'({ready_o, core_valid_o}), 128'({1'b1, 1'b0}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
